// File: rtl/chl_pattern_gen.sv
// Channel stimulus source: counter, walking-one, LFSR or hold patterns on CHLS channels with a rate divider.
// Optional burst limit (burst_i/done_o) is compiled in when CHL_PATTERN_GEN_BURST_EN is defined.
module chl_pattern_gen #(
  parameter int unsigned     CHLS  = 32,
  parameter int unsigned     DIV_W = 16,
  parameter logic [CHLS-1:0] TAPS  = CHLS'(32'h8020_0003)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [CHLS-1:0]  seed_i,
  input  logic             load_i,
`ifdef CHL_PATTERN_GEN_BURST_EN
  input  logic [15:0]      burst_i,
  output logic             done_o,
`endif
  output logic [CHLS-1:0]  chls_o,
  output logic             stb_o
);

  localparam logic [1:0] MODE_CNT  = 2'd0;
  localparam logic [1:0] MODE_WALK = 2'd1;
  localparam logic [1:0] MODE_LFSR = 2'd2;

  logic [DIV_W-1:0] div_cnt;
  logic             div_hit_c;
  logic             tick_c;
  logic [CHLS-1:0]  next_c;

  assign div_hit_c = en_i && (div_cnt == div_i);

`ifdef CHL_PATTERN_GEN_BURST_EN
  logic [15:0] burst_cnt;
  logic        stopped;
  logic        last_c;

  // Once the burst is exhausted the divider keeps running but no tick reaches the pattern.
  assign tick_c = div_hit_c && !stopped;
  assign last_c = (burst_i != 16'd0) && ((burst_cnt + 16'd1) == burst_i);
`else
  assign tick_c = div_hit_c;
`endif

  // Next generated pattern; an all-zero state escapes to 1 for walking-one and LFSR.
  always_comb begin
    next_c = chls_o;
    case (mode_i)
      MODE_CNT:  next_c = chls_o + CHLS'(1);
      MODE_WALK: next_c = (chls_o == '0) ? CHLS'(1) : {chls_o[CHLS-2:0], chls_o[CHLS-1]};
      MODE_LFSR: next_c = (chls_o == '0) ? CHLS'(1) : {chls_o[CHLS-2:0], ^(chls_o & TAPS)};
      default:   next_c = chls_o;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chls_o  <= '0;
      stb_o   <= 1'b0;
      div_cnt <= '0;
`ifdef CHL_PATTERN_GEN_BURST_EN
      burst_cnt <= 16'd0;
      stopped   <= 1'b0;
      done_o    <= 1'b0;
`endif
    end else if (load_i) begin
      chls_o  <= seed_i;
      stb_o   <= 1'b0;
      div_cnt <= '0;
`ifdef CHL_PATTERN_GEN_BURST_EN
      burst_cnt <= 16'd0;
      stopped   <= 1'b0;
      done_o    <= 1'b0;
`endif
    end else begin
      stb_o <= tick_c;
      if (en_i) begin
        div_cnt <= div_hit_c ? '0 : div_cnt + DIV_W'(1);
      end
      if (tick_c) begin
        chls_o <= next_c;
      end
`ifdef CHL_PATTERN_GEN_BURST_EN
      done_o <= tick_c && last_c;
      if (tick_c) begin
        burst_cnt <= burst_cnt + 16'd1;
        if (last_c) begin
          stopped <= 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_chl_pattern_gen.sv
// Self-checking bench for chl_pattern_gen: directed scenarios plus randomized traffic against a cycle model.
module tb_chl_pattern_gen;

  localparam logic [31:0] TAPS32 = 32'h8020_0003;
  localparam logic [15:0] TAPS16 = 16'hB400;

  logic        clk = 1'b0;
  logic        rst, en, load;
  logic [1:0]  mode;
  logic [15:0] div;
  logic [31:0] seed, chls;
  logic        stb;

  logic        en16, load16;
  logic [1:0]  mode16;
  logic [15:0] div16, seed16, chls16;
  logic        stb16;

  int vectors = 0;
  int errors  = 0;

  logic [31:0] m_chls;
  logic        m_stb;
  int          m_cnt;

  bit seen16 [65536];

  always #5 clk = ~clk;

`ifdef CHL_PATTERN_GEN_BURST_EN
  logic done32, done16;
`endif

  chl_pattern_gen #(.CHLS(32), .DIV_W(16), .TAPS(TAPS32)) u_dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode), .div_i(div),
    .seed_i(seed), .load_i(load),
`ifdef CHL_PATTERN_GEN_BURST_EN
    .burst_i(16'd0), .done_o(done32),
`endif
    .chls_o(chls), .stb_o(stb)
  );

  chl_pattern_gen #(.CHLS(16), .DIV_W(16), .TAPS(TAPS16)) u_dut16 (
    .clk_i(clk), .rst_i(rst), .en_i(en16), .mode_i(mode16), .div_i(div16),
    .seed_i(seed16), .load_i(load16),
`ifdef CHL_PATTERN_GEN_BURST_EN
    .burst_i(16'd0), .done_o(done16),
`endif
    .chls_o(chls16), .stb_o(stb16)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pattern rules written as plain arithmetic on the current value.
  function automatic logic [31:0] gen32(input logic [1:0] m, input logic [31:0] v);
    logic [31:0] fb;
    fb = 32'($countones(v & TAPS32) % 2);
    case (m)
      2'd0:    return v + 32'd1;
      2'd1:    return (v == 32'd0) ? 32'd1 : ((v << 1) | (v >> 31));
      2'd2:    return (v == 32'd0) ? 32'd1 : ((v << 1) | fb);
      default: return v;
    endcase
  endfunction

  function automatic logic [15:0] gen16(input logic [15:0] v);
    logic [15:0] fb;
    fb = 16'($countones(v & TAPS16) % 2);
    return (v == 16'd0) ? 16'd1 : ((v << 1) | fb);
  endfunction

  // Expected state after one clock edge with the inputs currently driven.
  task automatic model_edge();
    if (rst) begin
      m_chls = 32'd0; m_stb = 1'b0; m_cnt = 0;
    end else if (load) begin
      m_chls = seed; m_stb = 1'b0; m_cnt = 0;
    end else if (en) begin
      if (m_cnt == int'(div)) begin
        m_chls = gen32(mode, m_chls); m_stb = 1'b1; m_cnt = 0;
      end else begin
        m_stb = 1'b0; m_cnt = (m_cnt + 1) % 65536;
      end
    end else begin
      m_stb = 1'b0;
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; en = 1'b1; load = 1'b0; mode = 2'd0; div = 16'd2; seed = 32'd0;
    repeat (3) step();
    vectors++; if (chls !== 32'd0) begin errors++; $display("FAIL reset_chls: got %h expected %h", chls, 32'd0); end
    vectors++; if (stb !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b expected 0", stb); end
    rst = 1'b0;
    n = 0;
    while (stb !== 1'b1 && n < 20) begin step(); n++; end
    vectors++; if (n != 3) begin errors++; $display("FAIL reset_first_stb: got %0d cycles expected %0d", n, 3); end
    vectors++; if (chls !== 32'd1) begin errors++; $display("FAIL reset_first_val: got %h expected %h", chls, 32'd1); end
  endtask

  task automatic test_counter();
    logic [31:0] exp_v [3];
    exp_v = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    load = 1'b1; seed = 32'hFFFF_FFFE; div = 16'd0; mode = 2'd0; en = 1'b1;
    step();
    load = 1'b0;
    vectors++; if (chls !== 32'hFFFF_FFFE) begin errors++; $display("FAIL counter_load: got %h expected %h", chls, 32'hFFFF_FFFE); end
    vectors++; if (stb !== 1'b0) begin errors++; $display("FAIL counter_load_stb: got %b expected 0", stb); end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (chls !== exp_v[i]) begin errors++; $display("FAIL counter_val%0d: got %h expected %h", i, chls, exp_v[i]); end
      vectors++; if (stb !== 1'b1) begin errors++; $display("FAIL counter_stb%0d: got %b expected 1", i, stb); end
    end
  endtask

  task automatic test_walk();
    logic [31:0] e;
    load = 1'b1; seed = 32'd0; div = 16'd2; mode = 2'd1; en = 1'b1;
    step();
    load = 1'b0;
    for (int k = 0; k < 33; k++) begin
      for (int c = 0; c < 3; c++) begin
        step();
        vectors++;
        if (stb !== (c == 2)) begin errors++; $display("FAIL walk_stb k%0d c%0d: got %b expected %b", k, c, stb, (c == 2)); end
      end
      e = 32'd1 << (k % 32);
      vectors++; if (chls !== e) begin errors++; $display("FAIL walk_val k%0d: got %h expected %h", k, chls, e); end
    end
  endtask

  task automatic test_lfsr32();
    logic [31:0] e;
    load = 1'b1; seed = 32'd0; div = 16'd0; mode = 2'd2; en = 1'b1;
    step();
    load = 1'b0;
    e = 32'd0;
    for (int i = 0; i < 40; i++) begin
      e = gen32(2'd2, e);
      step();
      vectors++; if (chls !== e) begin errors++; $display("FAIL lfsr32_step%0d: got %h expected %h", i, chls, e); end
    end
  endtask

  task automatic test_load_priority();
    int n;
    load = 1'b1; seed = 32'h1234_5678; div = 16'd3; mode = 2'd0; en = 1'b1;
    step();
    load = 1'b0;
    repeat (3) step();
    load = 1'b1; seed = 32'hA5A5_0F0F;
    step();
    load = 1'b0;
    vectors++; if (chls !== 32'hA5A5_0F0F) begin errors++; $display("FAIL prio_load_val: got %h expected %h", chls, 32'hA5A5_0F0F); end
    vectors++; if (stb !== 1'b0) begin errors++; $display("FAIL prio_load_stb: got %b expected 0", stb); end
    n = 0;
    while (stb !== 1'b1 && n < 20) begin step(); n++; end
    vectors++; if (n != 4) begin errors++; $display("FAIL prio_next_tick: got %0d cycles expected %0d", n, 4); end
    vectors++; if (chls !== 32'hA5A5_0F10) begin errors++; $display("FAIL prio_next_val: got %h expected %h", chls, 32'hA5A5_0F10); end
  endtask

  task automatic test_en_stall();
    int n;
    load = 1'b1; seed = 32'd100; div = 16'd3; mode = 2'd0; en = 1'b1;
    step();
    load = 1'b0;
    step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++; if (stb !== 1'b0) begin errors++; $display("FAIL stall_stb%0d: got %b expected 0", i, stb); end
      vectors++; if (chls !== 32'd100) begin errors++; $display("FAIL stall_hold%0d: got %h expected %h", i, chls, 32'd100); end
    end
    en = 1'b1;
    n = 0;
    while (stb !== 1'b1 && n < 20) begin step(); n++; end
    vectors++; if (1 + 5 + n != 4 + 5) begin errors++; $display("FAIL stall_period: got %0d cycles expected %0d", 1 + 5 + n, 9); end
    vectors++; if (chls !== 32'd101) begin errors++; $display("FAIL stall_val: got %h expected %h", chls, 32'd101); end
  endtask

  task automatic test_rst_midrun();
    int n;
    load = 1'b1; seed = 32'd5; div = 16'd2; mode = 2'd0; en = 1'b1;
    step();
    load = 1'b0;
    repeat (4) step();
    vectors++; if (chls !== 32'd6) begin errors++; $display("FAIL midrst_pre: got %h expected %h", chls, 32'd6); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++; if (chls !== 32'd0) begin errors++; $display("FAIL midrst_chls: got %h expected %h", chls, 32'd0); end
    vectors++; if (stb !== 1'b0) begin errors++; $display("FAIL midrst_stb: got %b expected 0", stb); end
    n = 0;
    while (stb !== 1'b1 && n < 20) begin step(); n++; end
    vectors++; if (n != 3) begin errors++; $display("FAIL midrst_div_clr: got %0d cycles expected %0d", n, 3); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      load = (i == 0) || ($urandom_range(0, 19) == 0);
      if (load) begin
        seed = $urandom;
        div  = 16'($urandom_range(0, 3));
      end
      model_edge();
      step();
      vectors++; if (chls !== m_chls) begin errors++; $display("FAIL rand_chls%0d: got %h expected %h", i, chls, m_chls); end
      vectors++; if (stb !== m_stb) begin errors++; $display("FAIL rand_stb%0d: got %b expected %b", i, stb, m_stb); end
    end
    load = 1'b0;
  endtask

  task automatic test_lfsr16();
    logic [15:0] e;
    int bad;
    int shown;
    for (int i = 0; i < 65536; i++) seen16[i] = 1'b0;
    load16 = 1'b1; seed16 = 16'd0; mode16 = 2'd2; div16 = 16'd0; en16 = 1'b1;
    step();
    load16 = 1'b0;
    e = 16'd0; bad = 0; shown = 0;
    for (int t = 1; t <= 65536; t++) begin
      step();
      e = gen16(e);
      vectors++;
      if (chls16 !== e) begin
        errors++;
        if (shown < 10) begin shown++; $display("FAIL lfsr16_tick%0d: got %h expected %h", t, chls16, e); end
      end
      if (t <= 65535) begin
        if ($isunknown(chls16) || chls16 == 16'd0 || seen16[chls16]) bad++;
        else seen16[chls16] = 1'b1;
      end else begin
        vectors++; if (chls16 !== 16'd1) begin errors++; $display("FAIL lfsr16_wrap: got %h expected %h", chls16, 16'd1); end
      end
    end
    vectors++; if (bad != 0) begin errors++; $display("FAIL lfsr16_unique: got %0d repeats/zeros expected 0", bad); end
    en16 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; mode = 2'd0; div = 16'd0; seed = 32'd0;
    en16 = 1'b0; load16 = 1'b0; mode16 = 2'd0; div16 = 16'd0; seed16 = 16'd0;
    m_chls = 32'd0; m_stb = 1'b0; m_cnt = 0;
    test_reset();
    test_counter();
    test_walk();
    test_lfsr32();
    test_load_priority();
    test_en_stall();
    test_rst_midrun();
    test_random();
    test_lfsr16();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
